// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared types and constants for the multicycle control FSM
//
// Contents:
//   state_e      - FSM state encoding (also exported on the debug state port)
//   OP_*         - supported major opcodes
//   ALU_*        - main-ALU operation codes, shared with the execute stage
//   op_supported - true when an opcode belongs to the supported instruction set

package multicycle_control_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - combinational main-ALU operation decoder
//
// Ports:
//   opcode_i      in  7  latched opcode
//   funct3_i      in  3  latched funct3
//   funct7b5_i    in  1  latched funct7 bit 5
//   alu_control_o out 4  ALU operation code
//   illegal_o     out 1  opcode unsupported, or R-type funct combination unsupported

module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (opcode_i)
      OP_LD, OP_SD: alu_control_o = ALU_ADD;   // address = rs1 + imm
      OP_BEQ:       alu_control_o = ALU_SUB;   // equality via zero flag of rs1 - rs2
      OP_R: begin
        case (funct3_i)
          3'b000:  alu_control_o = funct7b5_i ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          default: illegal_o     = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM (fetch/decode/execute/memory/writeback)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   instr[31:0]           instruction word, captured in FETCH when imem_valid
//   imem_valid            instruction memory returned instr this cycle
//   dmem_ready            data-memory access complete (only looked at in MEM)
//   zero                  main-ALU zero flag (drives Branch for BEQ in EXEC)
//   imem_req, ir_load     fetch request / instruction-register load
//   pc_write, Branch      PC update strobe / next-PC mux select
//   alu_src               1 = immediate operand, 0 = rd2
//   mem_read, mem_write   data-memory strobes
//   reg_write, mem_to_reg register-file write / writeback source select
//   illegal_instr         one-cycle pulse for an unsupported instruction
//   alu_control_signal    main-ALU operation
//   state[2:0]            current FSM state (debug)

module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_valid,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic        Branch,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal_instr,
  output logic [3:0]  alu_control_signal,
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic [2:0] funct3_q, funct3_d;
  logic       f7b5_q, f7b5_d;

  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic       is_r, is_ld, is_sd, is_beq, op_ok;

  // Register, immediate and remaining funct7 bits belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode_i      (opcode_q),
    .funct3_i      (funct3_q),
    .funct7b5_i    (f7b5_q),
    .alu_control_o (dec_alu),
    .illegal_o     (dec_illegal)
  );

  assign is_r   = (opcode_q == OP_R);
  assign is_ld  = (opcode_q == OP_LD);
  assign is_sd  = (opcode_q == OP_SD);
  assign is_beq = (opcode_q == OP_BEQ);
  assign op_ok  = op_supported(opcode_q);

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    f7b5_d   = f7b5_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_valid) begin
          state_d  = DECODE;
          opcode_d = instr[6:0];
          funct3_d = instr[14:12];
          f7b5_d   = instr[30];
        end
      end
      // Unsupported opcodes retire here as a nop without visiting EXEC.
      DECODE: state_d = op_ok ? EXEC : FETCH;
      EXEC: begin
        if (is_r)               state_d = dec_illegal ? FETCH : WB;
        else if (is_ld || is_sd) state_d = MEM;
        else                     state_d = FETCH;
      end
      MEM: begin
        if (dmem_ready) state_d = is_ld ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opcode_q <= 7'd0;
      funct3_q <= 3'd0;
      f7b5_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      f7b5_q   <= f7b5_d;
    end
  end

  // Outputs are a pure decode of the current state and latched fields, so an
  // asynchronous reset to IDLE silences all of them in the same instant.
  always_comb begin
    imem_req           = 1'b0;
    ir_load            = 1'b0;
    pc_write           = 1'b0;
    Branch             = 1'b0;
    alu_src            = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    reg_write          = 1'b0;
    mem_to_reg         = 1'b0;
    illegal_instr      = 1'b0;
    alu_control_signal = ALU_ADD;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_valid;
      end
      DECODE: begin
        if (!op_ok) begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
        end
      end
      EXEC: begin
        if (is_r) begin
          if (dec_illegal) begin
            illegal_instr = 1'b1;
            pc_write      = 1'b1;
          end else begin
            alu_control_signal = dec_alu;
          end
        end else if (is_ld || is_sd) begin
          alu_src            = 1'b1;
          alu_control_signal = dec_alu;
        end else if (is_beq) begin
          alu_control_signal = dec_alu;
          pc_write           = 1'b1;
          Branch             = zero;
        end
      end
      MEM: begin
        mem_read  = is_ld;
        mem_write = is_sd;
        pc_write  = is_sd && dmem_ready;   // a store retires in MEM
      end
      WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = is_ld;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_valid, dmem_ready, zero;
  logic        imem_req, ir_load, pc_write, Branch, alu_src, mem_read, mem_write;
  logic        reg_write, mem_to_reg, illegal_instr;
  logic [3:0]  alu_control_signal;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instr              (instr),
    .imem_valid         (imem_valid),
    .dmem_ready         (dmem_ready),
    .zero               (zero),
    .imem_req           (imem_req),
    .ir_load            (ir_load),
    .pc_write           (pc_write),
    .Branch             (Branch),
    .alu_src            (alu_src),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .reg_write          (reg_write),
    .mem_to_reg         (mem_to_reg),
    .illegal_instr      (illegal_instr),
    .alu_control_signal (alu_control_signal),
    .state              (state)
  );

  // Flag positions in the packed output word {state, flags, alu}.
  localparam logic [9:0] F_REQ  = 10'b10_0000_0000;
  localparam logic [9:0] F_IRL  = 10'b01_0000_0000;
  localparam logic [9:0] F_PCW  = 10'b00_1000_0000;
  localparam logic [9:0] F_BR   = 10'b00_0100_0000;
  localparam logic [9:0] F_ASRC = 10'b00_0010_0000;
  localparam logic [9:0] F_MRD  = 10'b00_0001_0000;
  localparam logic [9:0] F_MWR  = 10'b00_0000_1000;
  localparam logic [9:0] F_REGW = 10'b00_0000_0100;
  localparam logic [9:0] F_M2R  = 10'b00_0000_0010;
  localparam logic [9:0] F_ILL  = 10'b00_0000_0001;

  typedef struct {
    logic        iv;
    logic        dr;
    logic        z;
    logic [31:0] ins;
    logic [16:0] exp;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    logic        z;
    int          lat;
    string       name;
  } vec_t;

  cyc_t trace[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [16:0] outs_now();
    return {state, imem_req, ir_load, pc_write, Branch, alu_src, mem_read, mem_write,
            reg_write, mem_to_reg, illegal_instr, alu_control_signal};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [2:0] st, input logic [9:0] fl, input logic [3:0] alu,
                      input logic iv, input logic dr, input logic z, input logic [31:0] ins);
    cyc_t c;
    c.iv = iv; c.dr = dr; c.z = z; c.ins = ins;
    c.exp = {st, fl, alu};
    trace.push_back(c);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Reference: one cycle-by-cycle record per state the instruction should occupy,
  // derived from the instruction class rules.
  task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic zf);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b5;
    logic [3:0] alu;
    logic       bad;
    logic       is_ld;
    op = ins[6:0]; f3 = ins[14:12]; b5 = ins[30];
    trace.delete();
    for (int i = 0; i < fw; i++) push(3'd1, F_REQ, 4'd0, 1'b0, rb(), rb(), $urandom);
    push(3'd1, F_REQ | F_IRL, 4'd0, 1'b1, rb(), rb(), ins);
    if (!(op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011)) begin
      push(3'd2, F_ILL | F_PCW, 4'd0, rb(), rb(), rb(), $urandom);
      return;
    end
    push(3'd2, 10'd0, 4'd0, rb(), rb(), rb(), $urandom);
    if (op == 7'b0110011) begin
      bad = 1'b0; alu = 4'd0;
      if (f3 == 3'd0)      alu = b5 ? 4'b0010 : 4'b0000;
      else if (f3 == 3'd1) alu = 4'b0001;
      else if (f3 == 3'd7) alu = 4'b0011;
      else if (f3 == 3'd6) alu = 4'b0100;
      else                 bad = 1'b1;
      if (bad) begin
        push(3'd3, F_ILL | F_PCW, 4'd0, rb(), rb(), rb(), $urandom);
      end else begin
        push(3'd3, 10'd0, alu, rb(), rb(), rb(), $urandom);
        push(3'd5, F_REGW | F_PCW, 4'd0, rb(), rb(), rb(), $urandom);
      end
    end else if (op == 7'b1100011) begin
      push(3'd3, F_PCW | (zf ? F_BR : 10'd0), 4'b0010, rb(), rb(), zf, $urandom);
    end else begin
      is_ld = (op == 7'b0000011);
      push(3'd3, F_ASRC, 4'd0, rb(), rb(), rb(), $urandom);
      for (int i = 0; i < mw; i++)
        push(3'd4, is_ld ? F_MRD : F_MWR, 4'd0, rb(), 1'b0, rb(), $urandom);
      push(3'd4, is_ld ? F_MRD : (F_MWR | F_PCW), 4'd0, rb(), 1'b1, rb(), $urandom);
      if (is_ld) push(3'd5, F_REGW | F_PCW | F_M2R, 4'd0, rb(), rb(), rb(), $urandom);
    end
  endtask

  task automatic apply(input string name, input int n, output int busy, output int pcw);
    logic [16:0] got;
    busy = 0; pcw = 0;
    for (int i = 0; i < n && i < trace.size(); i++) begin
      @(posedge clk); #1;
      imem_valid = trace[i].iv;
      dmem_ready = trace[i].dr;
      zero       = trace[i].z;
      instr      = trace[i].ins;
      @(negedge clk);
      got = outs_now();
      checks++;
      if (got !== trace[i].exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b required %b", name, i, got, trace[i].exp);
      end
      check({name, " rd_wr_exclusive"}, 32'(mem_read & mem_write), 32'd0);
      if (state != 3'd1) busy++;
      if (pc_write) pcw++;
    end
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy, pcw;
    logic [31:0] ins;
    int k;

    vecs[0]  = '{32'h002081B3, 0, 0, 1'b0, 4, "add"};
    vecs[1]  = '{32'h402081B3, 0, 0, 1'b0, 4, "sub"};
    vecs[2]  = '{32'h0020E1B3, 0, 0, 1'b0, 4, "or"};
    vecs[3]  = '{32'h002091B3, 1, 0, 1'b0, 4, "sll"};
    vecs[4]  = '{32'h0020F1B3, 0, 0, 1'b0, 4, "and"};
    vecs[5]  = '{32'h0000B183, 0, 0, 1'b0, 5, "ld_fast"};
    vecs[6]  = '{32'h0000B183, 0, 3, 1'b0, 8, "ld_wait3"};
    vecs[7]  = '{32'h0020B023, 0, 0, 1'b0, 4, "sd"};
    vecs[8]  = '{32'h00208463, 0, 0, 1'b1, 3, "beq_taken"};
    vecs[9]  = '{32'h00208463, 0, 0, 1'b0, 3, "beq_not"};
    vecs[10] = '{32'hFFFFFFFF, 0, 0, 1'b0, 2, "illegal_op"};
    vecs[11] = '{32'h0020A1B3, 0, 0, 1'b0, 3, "illegal_funct"};

    rst_n = 1'b0; instr = 32'd0; imem_valid = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs_now()), 32'd0);

    // Release; first imem_req is seen on the second rising edge.
    @(negedge clk); rst_n = 1'b1; #1;
    check("release_idle", 32'({state, imem_req}), 32'd0);
    @(posedge clk); #1 imem_valid = 1'b0;
    @(negedge clk);
    check("first_fetch", 32'({state, imem_req}), 32'({3'd1, 1'b1}));

    foreach (vecs[v]) begin
      build(vecs[v].ins, vecs[v].fw, vecs[v].mw, vecs[v].z);
      apply(vecs[v].name, trace.size(), busy, pcw);
      check({vecs[v].name, " latency"}, 32'(busy + 1), 32'(vecs[v].lat));
      check({vecs[v].name, " pc_write_count"}, 32'(pcw), 32'd1);
    end

    // Reset while a store is waiting in MEM.
    build(32'h0020B023, 0, 5, 1'b0);
    apply("sd_abort", 4, busy, pcw);
    check("sd_abort_no_pcw_before", 32'(pcw), 32'd0);
    check("sd_abort_in_mem", 32'({state, mem_write}), 32'({3'd4, 1'b1}));
    rst_n = 1'b0; #1;
    check("abort_immediate", 32'({state, mem_write, pc_write}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 dmem_ready = 1'b1; imem_valid = 1'b1;
      @(negedge clk);
      check("abort_held", 32'({state, pc_write, reg_write, mem_write}), 32'd0);
    end
    rst_n = 1'b1; dmem_ready = 1'b0; #1;
    check("abort_release_idle", 32'({state, imem_req}), 32'd0);
    @(posedge clk); #1 imem_valid = 1'b0;
    @(negedge clk);
    check("abort_refetch", 32'({state, imem_req}), 32'({3'd1, 1'b1}));

    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      k = $urandom_range(0, 4);
      case (k)
        0: ins[6:0] = 7'b0110011;
        1: ins[6:0] = 7'b0000011;
        2: ins[6:0] = 7'b0100011;
        3: ins[6:0] = 7'b1100011;
        default: ;
      endcase
      build(ins, $urandom_range(0, 2), $urandom_range(0, 3), rb());
      apply($sformatf("rand%0d", n), trace.size(), busy, pcw);
      check($sformatf("rand%0d pc_write_count", n), 32'(pcw), 32'd1);
    end

    @(posedge clk); #1 imem_valid = 1'b0;
    @(negedge clk);
    check("final_fetch", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
